// File: rtl/uart_core_param.sv
// uart_core_param: parametrised full-duplex UART with TX/RX FIFOs.
// Frame = start, DATA_BITS (LSB first), optional parity, STOP_BITS stops.
// RX FIFO is show-ahead; each entry carries {overrun, parity, framing} flags.
// Optional macro UART_LOOPBACK_EN adds a 'loopback' input that routes the
// internal tx into the receiver and parks the tx pin high.
module uart_core_param #(
   parameter int SYSTEM_CLOCK  = 99999001,
   parameter int UART_BAUDRATE = 115200,
   parameter int DATA_BITS     = 8,
   parameter int PARITY        = 0,
   parameter int STOP_BITS     = 1,
   parameter int OVERSAMPLE    = 16,
   parameter int FIFO_DEPTH    = 16
) (
   input  logic                        system_clk,
   input  logic                        reset,
   input  logic [DATA_BITS-1:0]        din,
   input  logic                        wr_en,
   output logic                        tx_full,
   output logic                        tx,
   output logic                        tx_busy,
   input  logic                        rx,
`ifdef UART_LOOPBACK_EN
   input  logic                        loopback,
`endif
   input  logic                        rd_en,
   output logic                        rx_valid,
   output logic [DATA_BITS-1:0]        dout,
   output logic [2:0]                  rx_error_bit,
   output logic [$clog2(FIFO_DEPTH):0] rx_fifo_level
);

   localparam int DIV_CALC = (SYSTEM_CLOCK + UART_BAUDRATE*OVERSAMPLE/2) / (UART_BAUDRATE*OVERSAMPLE);
   localparam int DIV      = (DIV_CALC < 1) ? 1 : DIV_CALC;
   localparam int DCW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int OSW      = $clog2(OVERSAMPLE);
   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int BW       = 4;
   localparam int EW       = DATA_BITS + 3;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

   // Parity bit that completes the frame for the configured mode.
   function automatic logic par_of(input logic [DATA_BITS-1:0] d);
      return (PARITY == 1) ? ~^d : ^d;
   endfunction

   // ---------------- baud tick ----------------
   logic [DCW-1:0] div_q;
   logic           tick;
   assign tick = (div_q == DCW'(DIV-1));

   // Free-running oversample divider.
   always_ff @(posedge system_clk) begin
      if (reset || tick) div_q <= '0;
      else               div_q <= div_q + DCW'(1);
   end

   // ---------------- TX FIFO ----------------
   logic [DATA_BITS-1:0] txf_mem_q [FIFO_DEPTH];
   logic [AW-1:0]        txf_wr_q, txf_rd_q;
   logic [AW:0]          txf_cnt_q;
   logic                 txf_empty, txf_push, tx_pop;
   logic [DATA_BITS-1:0] txf_head;

   assign txf_empty = (txf_cnt_q == '0);
   assign tx_full   = (txf_cnt_q == (AW+1)'(FIFO_DEPTH));
   // A pop in the same cycle frees a slot, so a write on full is still taken.
   assign txf_push  = wr_en && (!tx_full || tx_pop);
   assign txf_head  = txf_mem_q[txf_rd_q];

   // TX FIFO storage.
   always_ff @(posedge system_clk) begin
      if (!reset && txf_push) txf_mem_q[txf_wr_q] <= din;
   end

   // TX FIFO pointers and occupancy.
   always_ff @(posedge system_clk) begin
      if (reset) begin
         txf_wr_q  <= '0;
         txf_rd_q  <= '0;
         txf_cnt_q <= '0;
      end else begin
         if (txf_push) txf_wr_q <= txf_wr_q + AW'(1);
         if (tx_pop)   txf_rd_q <= txf_rd_q + AW'(1);
         txf_cnt_q <= txf_cnt_q + (AW+1)'(txf_push) - (AW+1)'(tx_pop);
      end
   end

   // ---------------- TX FSM ----------------
   state_e               tx_st_q, tx_st_d;
   logic [OSW-1:0]       tx_os_q, tx_os_d;
   logic [BW-1:0]        tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
   logic                 tx_par_q, tx_par_d;
   logic                 tx_bit_end, tx_int;

   assign tx_bit_end = tick && (tx_os_q == OSW'(OVERSAMPLE-1));

   // TX state register.
   always_ff @(posedge system_clk) begin
      if (reset) begin
         tx_st_q  <= S_IDLE;
         tx_os_q  <= '0;
         tx_bit_q <= '0;
         tx_sh_q  <= '0;
         tx_par_q <= 1'b0;
      end else begin
         tx_st_q  <= tx_st_d;
         tx_os_q  <= tx_os_d;
         tx_bit_q <= tx_bit_d;
         tx_sh_q  <= tx_sh_d;
         tx_par_q <= tx_par_d;
      end
   end

   // TX next state; a pop at the end of STOP chains frames with no idle gap.
   always_comb begin
      tx_st_d  = tx_st_q;
      tx_os_d  = tx_os_q;
      tx_bit_d = tx_bit_q;
      tx_sh_d  = tx_sh_q;
      tx_par_d = tx_par_q;
      tx_pop   = 1'b0;
      if (tx_st_q != S_IDLE && tick) tx_os_d = tx_os_q + OSW'(1);
      case (tx_st_q)
         S_IDLE: if (tick && !txf_empty) begin
            tx_pop  = 1'b1;
            tx_st_d = S_START;
            tx_os_d = '0;
         end
         S_START: if (tx_bit_end) begin
            tx_st_d  = S_DATA;
            tx_bit_d = '0;
         end
         S_DATA: if (tx_bit_end) begin
            tx_sh_d = tx_sh_q >> 1;
            if (tx_bit_q == BW'(DATA_BITS-1)) begin
               tx_bit_d = '0;
               tx_st_d  = (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
               tx_bit_d = tx_bit_q + BW'(1);
            end
         end
         S_PAR: if (tx_bit_end) begin
            tx_st_d  = S_STOP;
            tx_bit_d = '0;
         end
         S_STOP: if (tx_bit_end) begin
            if (tx_bit_q == BW'(STOP_BITS-1)) begin
               if (!txf_empty) begin
                  tx_pop  = 1'b1;
                  tx_st_d = S_START;
               end else begin
                  tx_st_d = S_IDLE;
               end
            end else begin
               tx_bit_d = tx_bit_q + BW'(1);
            end
         end
         default: tx_st_d = S_IDLE;
      endcase
      if (tx_pop) begin
         tx_sh_d  = txf_head;
         tx_par_d = par_of(txf_head);
      end
   end

   // Serial line level for the current TX state.
   always_comb begin
      case (tx_st_q)
         S_START: tx_int = 1'b0;
         S_DATA:  tx_int = tx_sh_q[0];
         S_PAR:   tx_int = tx_par_q;
         default: tx_int = 1'b1;
      endcase
   end

   assign tx_busy = !txf_empty || (tx_st_q != S_IDLE);

   logic rx_src;
`ifdef UART_LOOPBACK_EN
   assign tx     = loopback ? 1'b1 : tx_int;
   assign rx_src = loopback ? tx_int : rx;
`else
   assign tx     = tx_int;
   assign rx_src = rx;
`endif

   // ---------------- RX front end ----------------
   logic rx_s1_q, rx_s2_q, rx_s3_q, rx_fall;
   assign rx_fall = rx_s3_q && !rx_s2_q;

   // Two-flop synchroniser plus one delay stage for edge detection.
   always_ff @(posedge system_clk) begin
      if (reset) begin
         rx_s1_q <= 1'b1;
         rx_s2_q <= 1'b1;
         rx_s3_q <= 1'b1;
      end else begin
         rx_s1_q <= rx_src;
         rx_s2_q <= rx_s1_q;
         rx_s3_q <= rx_s2_q;
      end
   end

   // ---------------- RX FSM ----------------
   state_e               rx_st_q, rx_st_d;
   logic [OSW-1:0]       rx_os_q, rx_os_d;
   logic [BW-1:0]        rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
   logic                 rx_perr_q, rx_perr_d;
   logic                 rx_push, rx_half_end, rx_bit_end;
   logic [EW-1:0]        rx_word;

   assign rx_half_end = tick && (rx_os_q == OSW'(OVERSAMPLE/2-1));
   assign rx_bit_end  = tick && (rx_os_q == OSW'(OVERSAMPLE-1));
   // Overrun starts clear; framing is the inverted first stop sample.
   assign rx_word     = {1'b0, rx_perr_q, ~rx_s2_q, rx_sh_q};

   // RX state register.
   always_ff @(posedge system_clk) begin
      if (reset) begin
         rx_st_q   <= S_IDLE;
         rx_os_q   <= '0;
         rx_bit_q  <= '0;
         rx_sh_q   <= '0;
         rx_perr_q <= 1'b0;
      end else begin
         rx_st_q   <= rx_st_d;
         rx_os_q   <= rx_os_d;
         rx_bit_q  <= rx_bit_d;
         rx_sh_q   <= rx_sh_d;
         rx_perr_q <= rx_perr_d;
      end
   end

   // RX next state: centre-sample each bit once, push at the first stop bit.
   always_comb begin
      rx_st_d   = rx_st_q;
      rx_os_d   = rx_os_q;
      rx_bit_d  = rx_bit_q;
      rx_sh_d   = rx_sh_q;
      rx_perr_d = rx_perr_q;
      rx_push   = 1'b0;
      if (rx_st_q != S_IDLE && tick) rx_os_d = rx_os_q + OSW'(1);
      case (rx_st_q)
         S_IDLE: if (rx_fall) begin
            rx_st_d = S_START;
            rx_os_d = '0;
         end
         S_START: if (rx_half_end) begin
            if (rx_s2_q) begin
               rx_st_d = S_IDLE;
            end else begin
               rx_st_d   = S_DATA;
               rx_os_d   = '0;
               rx_bit_d  = '0;
               rx_perr_d = 1'b0;
            end
         end
         S_DATA: if (rx_bit_end) begin
            rx_sh_d = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
            if (rx_bit_q == BW'(DATA_BITS-1)) begin
               rx_bit_d = '0;
               rx_st_d  = (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
               rx_bit_d = rx_bit_q + BW'(1);
            end
         end
         S_PAR: if (rx_bit_end) begin
            rx_perr_d = rx_s2_q ^ par_of(rx_sh_q);
            rx_st_d   = S_STOP;
         end
         S_STOP: if (rx_bit_end) begin
            rx_push = 1'b1;
            rx_st_d = S_IDLE;
         end
         default: rx_st_d = S_IDLE;
      endcase
   end

   // ---------------- RX FIFO ----------------
   logic [EW-1:0] rxf_mem_q [FIFO_DEPTH];
   logic [AW-1:0] rxf_wr_q, rxf_rd_q;
   logic [AW:0]   rxf_cnt_q;
   logic          rxf_empty, rxf_full, rxf_pop, rxf_push, rxf_ovr;
   logic [EW-1:0] rxf_head;

   assign rxf_empty = (rxf_cnt_q == '0);
   assign rxf_full  = (rxf_cnt_q == (AW+1)'(FIFO_DEPTH));
   assign rxf_pop   = rd_en && !rxf_empty;
   assign rxf_push  = rx_push && (!rxf_full || rxf_pop);
   assign rxf_ovr   = rx_push && rxf_full && !rxf_pop;
   assign rxf_head  = rxf_mem_q[rxf_rd_q];

   // RX FIFO storage; a dropped word marks overrun on the newest entry.
   always_ff @(posedge system_clk) begin
      if (!reset) begin
         if (rxf_push)     rxf_mem_q[rxf_wr_q] <= rx_word;
         else if (rxf_ovr) rxf_mem_q[rxf_wr_q - AW'(1)][EW-1] <= 1'b1;
      end
   end

   // RX FIFO pointers and occupancy.
   always_ff @(posedge system_clk) begin
      if (reset) begin
         rxf_wr_q  <= '0;
         rxf_rd_q  <= '0;
         rxf_cnt_q <= '0;
      end else begin
         if (rxf_push) rxf_wr_q <= rxf_wr_q + AW'(1);
         if (rxf_pop)  rxf_rd_q <= rxf_rd_q + AW'(1);
         rxf_cnt_q <= rxf_cnt_q + (AW+1)'(rxf_push) - (AW+1)'(rxf_pop);
      end
   end

   assign rx_valid      = !rxf_empty;
   assign rx_fifo_level = rxf_cnt_q;
   assign dout          = rxf_empty ? '0 : rxf_head[DATA_BITS-1:0];
   assign rx_error_bit  = rxf_empty ? '0 : rxf_head[EW-1:DATA_BITS];

endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: 8 data bits, even parity, 2 stop bits,
// 4-deep FIFOs, DIV=1 so one bit is 16 clocks.
module tb_uart_core_param;
   localparam int DEPTH = 4;

   logic       system_clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] din = '0;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic       rx = 1'b1;
   logic       tx_full, tx, tx_busy, rx_valid;
   logic [7:0] dout;
   logic [2:0] rx_error_bit;
   logic [2:0] rx_fifo_level;
`ifdef UART_LOOPBACK_EN
   logic       loopback = 1'b0;
   logic       lb_low = 1'b0;
`endif

   int  total = 0;
   int  bad = 0;
   bit  chk_en = 1'b0;
   logic [10:0] mdl_q[$];   // expected RX FIFO contents {err[2:0], data}
   logic [11:0] tx_got[$];  // frames decoded from the tx pin, bit i = bit time i

   uart_core_param #(
      .SYSTEM_CLOCK(1843200), .UART_BAUDRATE(115200), .DATA_BITS(8), .PARITY(2),
      .STOP_BITS(2), .OVERSAMPLE(16), .FIFO_DEPTH(DEPTH)
   ) dut (
      .system_clk(system_clk), .reset(reset), .din(din), .wr_en(wr_en),
      .tx_full(tx_full), .tx(tx), .tx_busy(tx_busy), .rx(rx),
`ifdef UART_LOOPBACK_EN
      .loopback(loopback),
`endif
      .rd_en(rd_en), .rx_valid(rx_valid), .dout(dout),
      .rx_error_bit(rx_error_bit), .rx_fifo_level(rx_fifo_level)
   );

   always #5 system_clk = ~system_clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", nm, got, exp);
      end
   endtask

   // Expected line image of one frame: start, data LSB first, even parity, 2 stops.
   function automatic logic [11:0] tx_frame(input logic [7:0] b);
      return {2'b11, ^b, b, 1'b0};
   endfunction

   // RX FIFO model: a push onto a full FIFO flags the newest entry instead.
   task automatic mdl_push(input logic [10:0] e);
      logic [10:0] t;
      if (mdl_q.size() == DEPTH) begin
         t = mdl_q[DEPTH-1];
         t[10] = 1'b1;
         mdl_q[DEPTH-1] = t;
      end else begin
         mdl_q.push_back(e);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge system_clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      din = b; wr_en = 1'b1; cyc(1); wr_en = 1'b0;
   endtask

   // Drive one full frame on rx; parity can be corrupted and the first stop forced low.
   task automatic rx_frame(input logic [7:0] b, input bit flip, input bit stop0);
      logic [11:0] v;
      v = {1'b1, ~stop0, (^b) ^ flip, b, 1'b0};
      chk_en = 1'b0;
      for (int i = 0; i < 12; i++) begin
         rx = v[i];
         cyc(16);
      end
      rx = 1'b1;
      mdl_push({1'b0, flip, stop0, b});
      chk_en = 1'b1;
      cyc(4);
   endtask

   task automatic pop_chk(input string nm, input logic [7:0] d, input logic [2:0] e);
      chk({nm, "_valid"}, rx_valid, 1);
      chk({nm, "_dout"}, dout, d);
      chk({nm, "_err"}, rx_error_bit, e);
      rd_en = 1'b1; cyc(1); rd_en = 1'b0;
      if (mdl_q.size() != 0) mdl_q.delete(0);
   endtask

   task automatic wait_frames(input int n, input int budget);
      int k = 0;
      while (tx_got.size() < n && k < budget) begin
         cyc(1);
         k++;
      end
      chk("tx_frame_count", tx_got.size(), n);
   endtask

   // Per-cycle RX comparison against the FIFO model.
   always @(negedge system_clk) begin
      if (chk_en) begin
         chk("rx_valid", rx_valid, mdl_q.size() != 0);
         chk("rx_level", rx_fifo_level, mdl_q.size());
         if (mdl_q.size() != 0) begin
            chk("rx_dout", dout, mdl_q[0][7:0]);
            chk("rx_err", rx_error_bit, mdl_q[0][10:8]);
         end
      end
   end

   // TX line monitor: centre-samples 12 bit times after each falling edge.
   logic        mon_p = 1'b1;
   logic [11:0] mon_v;
   initial begin
      forever begin
         @(negedge system_clk);
         if (mon_p && !tx) begin
            repeat (7) @(negedge system_clk);
            mon_v[0] = tx;
            for (int i = 1; i < 12; i++) begin
               repeat (16) @(negedge system_clk);
               mon_v[i] = tx;
            end
            tx_got.push_back(mon_v);
         end
         mon_p = tx;
      end
   end

`ifdef UART_LOOPBACK_EN
   always @(negedge system_clk) if (loopback && !tx) lb_low = 1'b1;
`endif

   initial begin
      #1000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   logic [7:0] fill [5];
   int k;
   initial begin
      fill[0] = 8'h0F; fill[1] = 8'hA1; fill[2] = 8'hB2; fill[3] = 8'hC3; fill[4] = 8'hD4;
      cyc(3);
      chk("rst_tx", tx, 1);
      chk("rst_tx_busy", tx_busy, 0);
      chk("rst_tx_full", tx_full, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_dout", dout, 0);
      chk("rst_err", rx_error_bit, 0);
      chk("rst_level", rx_fifo_level, 0);
      reset = 1'b0;
      chk_en = 1'b1;
      cyc(2);

      // TX frames against hand-computed line images
      send_byte(8'hA5);
      wait_frames(1, 400);
      if (tx_got.size() > 0) chk("tx_a5", tx_got[0], 12'hD4A);
      tx_got.delete();
      send_byte(8'h35);
      wait_frames(1, 400);
      if (tx_got.size() > 0) chk("tx_35", tx_got[0], 12'hC6A);
      tx_got.delete();
      cyc(20);
      chk("tx_idle_busy", tx_busy, 0);

      // RX: clean, parity error, framing error followed by a clean frame
      rx_frame(8'hA5, 0, 0);
      pop_chk("rx_a5", 8'hA5, 3'b000);
      rx_frame(8'h35, 1, 0);
      pop_chk("rx_35_par", 8'h35, 3'b010);
      rx_frame(8'h3C, 0, 1);
      rx_frame(8'h81, 0, 0);
      pop_chk("rx_3c_frm", 8'h3C, 3'b001);
      pop_chk("rx_81", 8'h81, 3'b000);

      // short low pulse is rejected
      rx = 1'b0; cyc(3); rx = 1'b1; cyc(40);
      chk("glitch_level", rx_fifo_level, 0);

      // RX overrun: 5 frames into a 4-deep FIFO
      rx_frame(8'h11, 0, 0);
      rx_frame(8'h22, 0, 0);
      rx_frame(8'h33, 0, 0);
      rx_frame(8'h44, 0, 0);
      rx_frame(8'h55, 0, 0);
      chk("ovr_level", rx_fifo_level, 4);
      pop_chk("ovr_e1", 8'h11, 3'b000);
      pop_chk("ovr_e2", 8'h22, 3'b000);
      pop_chk("ovr_e3", 8'h33, 3'b000);
      pop_chk("ovr_e4", 8'h44, 3'b100);
      chk("ovr_drained", rx_valid, 0);

      // TX FIFO full while the shifter is busy: fifth queued byte is dropped
      send_byte(fill[0]);
      cyc(3);
      wr_en = 1'b1;
      din = fill[1]; cyc(1);
      din = fill[2]; cyc(1);
      din = fill[3]; cyc(1);
      chk("tx_full_3", tx_full, 0);
      din = fill[4]; cyc(1);
      chk("tx_full_4", tx_full, 1);
      din = 8'hE5; cyc(1);
      wr_en = 1'b0;
      chk("tx_full_drop", tx_full, 1);
      wait_frames(5, 1400);
      cyc(300);
      chk("tx_no_6th", tx_got.size(), 5);
      for (int j = 0; j < 5; j++)
         if (j < tx_got.size()) chk($sformatf("tx_fill%0d", j), tx_got[j], tx_frame(fill[j]));
      chk("tx_fill_busy", tx_busy, 0);
      tx_got.delete();

      // reset in the middle of a TX data bit with a partial RX frame running
      send_byte(8'h00);
      rx = 1'b0;
      k = 0;
      while (tx !== 1'b0 && k < 100) begin cyc(1); k++; end
      chk("rst_mid_start", tx, 0);
      cyc(40);
      chk("rst_mid_data", tx, 0);
      reset = 1'b1; cyc(1);
      chk("rst_mid_tx", tx, 1);
      chk("rst_mid_busy", tx_busy, 0);
      chk("rst_mid_level", rx_fifo_level, 0);
      reset = 1'b0; rx = 1'b1;
      mdl_q.delete();
      cyc(300);
      chk("rst_no_push", rx_valid, 0);
      chk("rst_tx_idle", tx, 1);
      tx_got.delete();

`ifdef UART_LOOPBACK_EN
      loopback = 1'b1; lb_low = 1'b0; chk_en = 1'b0;
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
      k = 0;
      while (rx_fifo_level != 3 && k < 1500) begin cyc(1); k++; end
      chk("lb_level", rx_fifo_level, 3);
      mdl_push({3'b000, 8'h00}); mdl_push({3'b000, 8'hFF}); mdl_push({3'b000, 8'h5A});
      chk_en = 1'b1;
      pop_chk("lb_00", 8'h00, 3'b000);
      pop_chk("lb_ff", 8'hFF, 3'b000);
      pop_chk("lb_5a", 8'h5A, 3'b000);
      chk("lb_tx_high", lb_low, 0);
      loopback = 1'b0;
      cyc(4);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
